// File: rtl/addsub_pkg.sv
// Shared constants and types for the multi-nibble add/subtract sequencer.
package addsub_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic MODE_ADD = 1'b1;
    localparam logic MODE_SUB = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/addsub_sequencer_if.sv
// Operand/result handshake bundle between the switch front end and the sequencer.
interface addsub_sequencer_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic         setup;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         co;

    modport master (
        output start, setup, a, b, ci,
        input  busy, done, s, co
    );

    modport slave (
        input  start, setup, a, b, ci,
        output busy, done, s, co
    );

endinterface

// File: rtl/nibble_addsub.sv
// Combinational 4-bit add/subtract slice; co is carry-out on add, borrow-out on subtract.
module nibble_addsub
    import addsub_pkg::*;
(
    input  logic       mode,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [4:0] sum5;
    logic [4:0] diff5;

    // 5-bit arithmetic: bit 4 is carry for the sum, sign (borrow) for the difference
    always_comb begin
        sum5  = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
        diff5 = {1'b0, a} - {1'b0, b} - {4'b0000, ci};
        s     = 4'h0;
        co    = 1'b0;
        case (mode)
            MODE_ADD: begin
                s  = sum5[3:0];
                co = sum5[4];
            end
            MODE_SUB: begin
                s  = diff5[3:0];
                co = diff5[4];
            end
            default: begin
                s  = 4'h0;
                co = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/addsub_sequencer.sv
// Sequences one shared 4-bit add/subtract slice across NIBBLES nibbles, LSB first,
// chaining carry/borrow; result and carry are published only when the last nibble lands.
module addsub_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    addsub_sequencer_if.slave bus
);
    import addsub_pkg::*;

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_e                           state_q;
    logic [NIBBLES-1:0][NIBBLE_W-1:0] a_q;
    logic [NIBBLES-1:0][NIBBLE_W-1:0] b_q;
    logic [NIBBLES-1:0][NIBBLE_W-1:0] work_q;
    logic [NIBBLES-1:0][NIBBLE_W-1:0] s_d;
    logic                             mode_q;
    logic                             carry_q;
    logic [IDX_W-1:0]                 idx_q;
    logic                             busy_q;
    logic                             done_q;
    logic [W-1:0]                     s_q;
    logic                             co_q;

    logic [NIBBLE_W-1:0] slice_a;
    logic [NIBBLE_W-1:0] slice_b;
    logic [NIBBLE_W-1:0] slice_s;
    logic                slice_co;

    // Nibble mux: feed the currently indexed operand nibbles to the shared slice
    always_comb begin
        slice_a = a_q[idx_q];
        slice_b = b_q[idx_q];
    end

    nibble_addsub u_slice (
        .mode (mode_q),
        .a    (slice_a),
        .b    (slice_b),
        .ci   (carry_q),
        .s    (slice_s),
        .co   (slice_co)
    );

    // Final word: earlier nibbles from the work register, top nibble straight from the slice
    always_comb begin
        s_d         = work_q;
        s_d[idx_q]  = slice_s;
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            mode_q  <= MODE_SUB;
            carry_q <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            s_q     <= '0;
            co_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                RUN: begin
                    work_q[idx_q] <= slice_s;
                    carry_q       <= slice_co;
                    idx_q         <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        s_q     <= s_d;
                        co_q    <= slice_co;
                        idx_q   <= '0;
                    end
                end
                IDLE, DONE: begin
                    // DONE accepts a new start just like IDLE, giving back-to-back operation
                    if (bus.start) begin
                        state_q <= RUN;
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        mode_q  <= bus.setup;
                        carry_q <= bus.ci;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.s    = s_q;
    assign bus.co   = co_q;

endmodule

// File: tb/tb_addsub_sequencer.sv
// Directed self-checking bench for addsub_sequencer (NIBBLES = 4, 16-bit operands).
module tb_addsub_sequencer;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    addsub_sequencer_if #(.NIBBLES(4)) bus ();

    addsub_sequencer #(.NIBBLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation, scramble operands after acceptance, and wait (bounded) for done.
    // lat = cycle index of done (acceptance edge ends cycle 0), 99 on timeout.
    task automatic run_op(input logic md, input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic tci, output logic [15:0] rs, output logic rco,
                          output int lat, output logic [15:0] bmask);
        lat   = 99;
        rs    = '0;
        rco   = 1'b0;
        bmask = '0;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.setup = md;
        bus.a     = ta;
        bus.b     = tb_v;
        bus.ci    = tci;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a     = ~ta;
        bus.b     = ~tb_v;
        bus.ci    = ~tci;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            bmask[c] = bus.busy;
            if (bus.done) begin
                lat = c;
                rs  = bus.s;
                rco = bus.co;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.setup = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.ci    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        tests++; if (bus.s !== 16'h0000) begin fails++; $display("FAIL reset_s got=%h exp=0000", bus.s); end
        tests++; if (bus.co !== 1'b0) begin fails++; $display("FAIL reset_co got=%b exp=0", bus.co); end
        rst = 1'b0;
    endtask

    task automatic test_add();
        logic [15:0] rs, bm;
        logic        rco;
        int          lat;
        run_op(1'b1, 16'h1234, 16'h0FFF, 1'b0, rs, rco, lat, bm);
        tests++; if (lat !== 5) begin fails++; $display("FAIL add_latency got=%0d exp=5", lat); end
        tests++; if (rs !== 16'h2233) begin fails++; $display("FAIL add_s got=%h exp=2233", rs); end
        tests++; if (rco !== 1'b0) begin fails++; $display("FAIL add_co got=%b exp=0", rco); end
        tests++; if (bm !== 16'h001E) begin fails++; $display("FAIL add_busy_cycles got=%h exp=001e", bm); end
    endtask

    task automatic test_add_overflow();
        logic [15:0] rs, bm;
        logic        rco;
        int          lat;
        run_op(1'b1, 16'hFFFF, 16'h0001, 1'b0, rs, rco, lat, bm);
        tests++; if (rs !== 16'h0000) begin fails++; $display("FAIL ovf_s got=%h exp=0000", rs); end
        tests++; if (rco !== 1'b1) begin fails++; $display("FAIL ovf_co got=%b exp=1", rco); end
        run_op(1'b1, 16'h00FF, 16'h0000, 1'b1, rs, rco, lat, bm);
        tests++; if (rs !== 16'h0100) begin fails++; $display("FAIL add_ci_s got=%h exp=0100", rs); end
        tests++; if (rco !== 1'b0) begin fails++; $display("FAIL add_ci_co got=%b exp=0", rco); end
    endtask

    task automatic test_sub();
        logic [15:0] rs, bm;
        logic        rco;
        int          lat;
        run_op(1'b0, 16'h1000, 16'h0001, 1'b0, rs, rco, lat, bm);
        tests++; if (rs !== 16'h0FFF) begin fails++; $display("FAIL sub1_s got=%h exp=0fff", rs); end
        tests++; if (rco !== 1'b0) begin fails++; $display("FAIL sub1_co got=%b exp=0", rco); end
        run_op(1'b0, 16'h0000, 16'h0001, 1'b0, rs, rco, lat, bm);
        tests++; if (rs !== 16'hFFFF) begin fails++; $display("FAIL sub2_s got=%h exp=ffff", rs); end
        tests++; if (rco !== 1'b1) begin fails++; $display("FAIL sub2_co got=%b exp=1", rco); end
        run_op(1'b0, 16'h0005, 16'h0003, 1'b1, rs, rco, lat, bm);
        tests++; if (rs !== 16'h0001) begin fails++; $display("FAIL sub3_s got=%h exp=0001", rs); end
        tests++; if (rco !== 1'b0) begin fails++; $display("FAIL sub3_co got=%b exp=0", rco); end
        tests++; if (lat !== 5) begin fails++; $display("FAIL sub3_latency got=%0d exp=5", lat); end
    endtask

    // Start pulsed mid-run with other operands and operands toggled: only the first op counts
    task automatic test_ignore_start();
        int          ndone = 0;
        int          dcyc  = 99;
        logic [15:0] ds    = '0;
        logic        dco   = 1'b1;
        logic [15:0] s4    = '0;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.setup = 1'b1;
        bus.a     = 16'h0002;
        bus.b     = 16'h0003;
        bus.ci    = 1'b0;
        @(posedge clk); #1;
        for (int c = 1; c <= 14; c++) begin
            if (c == 1) begin bus.start = 1'b0; bus.a = 16'hABCD; bus.b = 16'h7777; bus.ci = 1'b1; end
            if (c == 2) begin bus.start = 1'b1; bus.setup = 1'b0; bus.a = 16'hFFFF; bus.b = 16'hFFFF; end
            if (c == 3) begin bus.start = 1'b0; bus.a = 16'h5A5A; end
            @(negedge clk);
            if (c == 4) s4 = bus.s;
            if (bus.done) begin
                ndone++;
                if (dcyc == 99) begin dcyc = c; ds = bus.s; dco = bus.co; end
            end
            @(posedge clk); #1;
        end
        tests++; if (ndone !== 1) begin fails++; $display("FAIL ign_done_count got=%0d exp=1", ndone); end
        tests++; if (dcyc !== 5) begin fails++; $display("FAIL ign_done_cycle got=%0d exp=5", dcyc); end
        tests++; if (ds !== 16'h0005) begin fails++; $display("FAIL ign_s got=%h exp=0005", ds); end
        tests++; if (dco !== 1'b0) begin fails++; $display("FAIL ign_co got=%b exp=0", dco); end
        tests++; if (s4 !== 16'h0001) begin fails++; $display("FAIL ign_s_hold got=%h exp=0001", s4); end
    endtask

    // Start held through the DONE cycle: second op accepted, its done 5 cycles later
    task automatic test_back_to_back();
        int          ndone = 0;
        int          d1 = 99, d2 = 99;
        logic [15:0] ds1 = '0, ds2 = '0, s7 = '0;
        logic        b6 = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.setup = 1'b1;
        bus.a     = 16'h0001;
        bus.b     = 16'h0001;
        bus.ci    = 1'b0;
        @(posedge clk); #1;
        for (int c = 1; c <= 14; c++) begin
            if (c == 1) begin bus.a = 16'h0010; bus.b = 16'h0020; end
            if (c == 6) begin bus.start = 1'b0; end
            @(negedge clk);
            if (c == 6) b6 = bus.busy;
            if (c == 7) s7 = bus.s;
            if (bus.done) begin
                ndone++;
                if (d1 == 99) begin d1 = c; ds1 = bus.s; end
                else if (d2 == 99) begin d2 = c; ds2 = bus.s; end
            end
            @(posedge clk); #1;
        end
        tests++; if (ndone !== 2) begin fails++; $display("FAIL b2b_done_count got=%0d exp=2", ndone); end
        tests++; if (d1 !== 5) begin fails++; $display("FAIL b2b_first_done got=%0d exp=5", d1); end
        tests++; if (d2 !== 10) begin fails++; $display("FAIL b2b_second_done got=%0d exp=10", d2); end
        tests++; if (ds1 !== 16'h0002) begin fails++; $display("FAIL b2b_s1 got=%h exp=0002", ds1); end
        tests++; if (ds2 !== 16'h0030) begin fails++; $display("FAIL b2b_s2 got=%h exp=0030", ds2); end
        tests++; if (s7 !== 16'h0002) begin fails++; $display("FAIL b2b_s_hold got=%h exp=0002", s7); end
        tests++; if (b6 !== 1'b1) begin fails++; $display("FAIL b2b_busy_after got=%b exp=1", b6); end
    endtask

    // Reset at cycle 3 of an add aborts it; a fresh op then completes normally
    task automatic test_reset_mid();
        int          ndone = 0;
        logic        b4 = 1'b1, d4 = 1'b1, c4 = 1'b1;
        logic [15:0] s4 = 16'hFFFF;
        logic [15:0] rs, bm;
        logic        rco;
        int          lat;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.setup = 1'b1;
        bus.a     = 16'h1234;
        bus.b     = 16'h1111;
        bus.ci    = 1'b0;
        @(posedge clk); #1;
        for (int c = 1; c <= 10; c++) begin
            if (c == 1) bus.start = 1'b0;
            if (c == 3) rst = 1'b1;
            if (c == 4) rst = 1'b0;
            @(negedge clk);
            if (c == 4) begin b4 = bus.busy; d4 = bus.done; s4 = bus.s; c4 = bus.co; end
            if (bus.done) ndone++;
            @(posedge clk); #1;
        end
        tests++; if (b4 !== 1'b0) begin fails++; $display("FAIL rst_busy got=%b exp=0", b4); end
        tests++; if (d4 !== 1'b0) begin fails++; $display("FAIL rst_done got=%b exp=0", d4); end
        tests++; if (s4 !== 16'h0000) begin fails++; $display("FAIL rst_s got=%h exp=0000", s4); end
        tests++; if (c4 !== 1'b0) begin fails++; $display("FAIL rst_co got=%b exp=0", c4); end
        tests++; if (ndone !== 0) begin fails++; $display("FAIL rst_no_done got=%0d exp=0", ndone); end
        run_op(1'b1, 16'h0F0F, 16'h00F1, 1'b0, rs, rco, lat, bm);
        tests++; if (lat !== 5) begin fails++; $display("FAIL rst_fresh_latency got=%0d exp=5", lat); end
        tests++; if (rs !== 16'h1000) begin fails++; $display("FAIL rst_fresh_s got=%h exp=1000", rs); end
        tests++; if (rco !== 1'b0) begin fails++; $display("FAIL rst_fresh_co got=%b exp=0", rco); end
    endtask

    // busy and done must never be high together
    always @(negedge clk) begin
        if (!rst && bus.busy === 1'b1 && bus.done === 1'b1) begin
            tests++;
            fails++;
            $display("FAIL busy_done_overlap got=11 exp=not both");
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_add();
        test_add_overflow();
        test_sub();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
